// File: rtl/regbank_write_port.sv
// regbank_write_port: writer-side front end of the 64-bit x 32 register bank.
// Accepts result writes from EX and MEM (MEM has priority), queues them in an
// in-order circular write buffer, drains one entry per cycle into the bank's
// single write port, and forwards still-pending values to the two read ports.
//
// Ports
//   clock, reset_n                  rising-edge clock, async active-low reset
//   ex_valid/ex_ready/ex_addr/ex_data      EX write request channel
//   mem_valid/mem_ready/mem_addr/mem_data  MEM write request channel
//   drain_en                        bank write port available this cycle
//   rb_write/rb_addr/rb_data        bank write port (bank index is {1'b0, rb_addr})
//   rd_addr1/rd_addr2               bank read port indices
//   byp_hit1/byp_data1, byp_hit2/byp_data2   forwarded pending values
//   count/full/empty                buffer occupancy
module regbank_write_port #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DEPTH      = 4,
   parameter bit          ZR_DISCARD = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     ex_valid,
   output logic                     ex_ready,
   input  logic [ADDR_W-1:0]        ex_addr,
   input  logic [DATA_W-1:0]        ex_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_data,
   input  logic                     drain_en,
   output logic                     rb_write,
   output logic [ADDR_W-1:0]        rb_addr,
   output logic [DATA_W-1:0]        rb_data,
   input  logic [ADDR_W-1:0]        rd_addr1,
   input  logic [ADDR_W-1:0]        rd_addr2,
   output logic                     byp_hit1,
   output logic [DATA_W-1:0]        byp_data1,
   output logic                     byp_hit2,
   output logic [DATA_W-1:0]        byp_data2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] ZR_ADDR = ADDR_W'(31);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              mem_fire;
   logic              ex_fire;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              push;
   logic              pop;

   // Handshake, enqueue selection and drain control
   always_comb begin
      empty     = (cnt_q == '0);
      full      = (cnt_q == CNT_W'(DEPTH));
      count     = cnt_q;
      mem_ready = !full;
      ex_ready  = !full && !mem_valid;
      mem_fire  = mem_valid && mem_ready;
      ex_fire   = ex_valid && ex_ready;
      in_addr   = mem_fire ? mem_addr : ex_addr;
      in_data   = mem_fire ? mem_data : ex_data;
      // XZR writes complete the handshake but never occupy an entry
      push      = (mem_fire || ex_fire) && !(ZR_DISCARD && (in_addr == ZR_ADDR));
      pop       = !empty && drain_en;
      rb_write  = pop;
      rb_addr   = addr_q[rd_ptr_q];
      rb_data   = data_q[rd_ptr_q];
   end

   // Pointer, occupancy and valid-bit state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         vld_q    <= '0;
      end else begin
         if (pop) begin
            rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            vld_q[rd_ptr_q] <= 1'b0;
         end
         // Push never targets the popped slot: push requires !full
         if (push) begin
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            vld_q[wr_ptr_q] <= 1'b1;
         end
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry payload storage
   always_ff @(posedge clock) begin
      if (push) begin
         addr_q[wr_ptr_q] <= in_addr;
         data_q[wr_ptr_q] <= in_data;
      end
   end

   // Youngest-match search: walk oldest to youngest so the last hit wins
   function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] ra);
      logic              hit;
      logic [DATA_W-1:0] d;
      logic [PTR_W-1:0]  idx;
      hit = 1'b0;
      d   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if (vld_q[idx] && (addr_q[idx] == ra)) begin
            hit = 1'b1;
            d   = data_q[idx];
         end
      end
      if (ZR_DISCARD && (ra == ZR_ADDR)) begin
         hit = 1'b0;
         d   = '0;
      end
      return {hit, d};
   endfunction

   // Read-port bypass
   always_comb begin
      {byp_hit1, byp_data1} = lookup(rd_addr1);
      {byp_hit2, byp_data2} = lookup(rd_addr2);
   end

endmodule

// File: tb/tb_regbank_write_port.sv
// Scoreboarded bench for regbank_write_port: expected bank writes are queued
// at acceptance and checked by a forked monitor as the DUT drains them.
module tb_regbank_write_port;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clock;
   logic              reset_n;
   logic              ex_valid, ex_ready;
   logic [ADDR_W-1:0] ex_addr;
   logic [DATA_W-1:0] ex_data;
   logic              mem_valid, mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              drain_en;
   logic              rb_write;
   logic [ADDR_W-1:0] rb_addr;
   logic [DATA_W-1:0] rb_data;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2;
   logic              byp_hit1, byp_hit2;
   logic [DATA_W-1:0] byp_data1, byp_data2;
   logic [CNT_W-1:0]  count;
   logic              full, empty;

   int   errors = 0;
   int   checks = 0;
   wr_t  exp_q[$];

   regbank_write_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZR_DISCARD(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .drain_en(drain_en),
      .rb_write(rb_write), .rb_addr(rb_addr), .rb_data(rb_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .byp_hit1(byp_hit1), .byp_data1(byp_data1),
      .byp_hit2(byp_hit2), .byp_data2(byp_data2),
      .count(count), .full(full), .empty(empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   // Bank-side monitor: every cycle with rb_write is a write at the next edge
   task automatic monitor();
      wr_t w;
      forever begin
         @(negedge clock);
         if (reset_n && rb_write) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bank_unexpected: write r%0d=%0h with nothing pending", rb_addr, rb_data);
            end else begin
               w = exp_q.pop_front();
               check("bank_addr", DATA_W'(rb_addr), DATA_W'(w.addr));
               check("bank_data", rb_data, w.data);
            end
         end
      end
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (!empty && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", DATA_W'(empty), DATA_W'(1));
   endtask

   initial begin
      fork
         monitor();
      join_none

      reset_n = 1'b0;
      ex_valid = 1'b0; ex_addr = '0; ex_data = '0;
      mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
      drain_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
      #12;
      check("rst_count",     DATA_W'(count),     '0);
      check("rst_empty",     DATA_W'(empty),     DATA_W'(1));
      check("rst_full",      DATA_W'(full),      '0);
      check("rst_rb_write",  DATA_W'(rb_write),  '0);
      check("rst_ex_ready",  DATA_W'(ex_ready),  DATA_W'(1));
      check("rst_mem_ready", DATA_W'(mem_ready), DATA_W'(1));
      check("rst_byp_hit1",  DATA_W'(byp_hit1),  '0);
      check("rst_byp_hit2",  DATA_W'(byp_hit2),  '0);
      reset_n = 1'b1;
      step();

      // MEM priority over EX
      drain_en = 1'b1;
      mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 64'hAA;
      ex_valid  = 1'b1; ex_addr  = 5'd7; ex_data  = 64'hBB;
      #1;
      check("prio_mem_ready", DATA_W'(mem_ready), DATA_W'(1));
      check("prio_ex_ready",  DATA_W'(ex_ready),  '0);
      expect_write(5'd5, 64'hAA);
      step();
      mem_valid = 1'b0;
      #1;
      check("prio_ex_ready2", DATA_W'(ex_ready), DATA_W'(1));
      expect_write(5'd7, 64'hBB);
      step();
      ex_valid = 1'b0;
      #1;
      check("prio_count", DATA_W'(count), DATA_W'(1));
      wait_empty(10);

      // Fill to full with drain stalled, then release
      drain_en = 1'b0;
      ex_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ex_addr = ADDR_W'(10 + k);
         ex_data = DATA_W'(64'h100 + k);
         #1;
         check("fill_ex_ready", DATA_W'(ex_ready), DATA_W'(k < 4));
         if (k < 4) expect_write(ex_addr, ex_data);
         step();
      end
      check("fill_full",  DATA_W'(full),  DATA_W'(1));
      check("fill_count", DATA_W'(count), DATA_W'(4));
      drain_en = 1'b1;
      #1;
      check("full_no_enq_on_drain", DATA_W'(ex_ready), '0);
      step();
      check("fill_ready_after_pop", DATA_W'(ex_ready), DATA_W'(1));
      expect_write(ex_addr, ex_data);
      step();
      ex_valid = 1'b0;
      check("fill_count_after", DATA_W'(count), DATA_W'(3));
      wait_empty(10);

      // Bypass: youngest match, incoming not forwarded, draining head forwards
      drain_en = 1'b0;
      rd_addr1 = 5'd3; rd_addr2 = 5'd4;
      ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 64'h11;
      #1;
      check("byp_incoming_hit1", DATA_W'(byp_hit1), '0);
      expect_write(5'd3, 64'h11);
      step();
      ex_data = 64'h22;
      #1;
      check("byp_older_data1", byp_data1, 64'h11);
      expect_write(5'd3, 64'h22);
      step();
      ex_valid = 1'b0;
      #1;
      check("byp_hit1",  DATA_W'(byp_hit1), DATA_W'(1));
      check("byp_data1", byp_data1, 64'h22);
      check("byp_hit2",  DATA_W'(byp_hit2), '0);
      check("byp_data2", byp_data2, '0);
      drain_en = 1'b1;
      #1;
      check("byp_head_drain_data1", byp_data1, 64'h22);
      step();
      check("byp_last_hit1",  DATA_W'(byp_hit1), DATA_W'(1));
      check("byp_last_data1", byp_data1, 64'h22);
      step();
      check("byp_gone_hit1", DATA_W'(byp_hit1), '0);

      // XZR discard
      ex_valid = 1'b1; ex_addr = 5'd31; ex_data = 64'hDEAD; rd_addr1 = 5'd31;
      #1;
      check("zr_ex_ready", DATA_W'(ex_ready), DATA_W'(1));
      check("zr_byp_hit1", DATA_W'(byp_hit1), '0);
      step();
      ex_valid = 1'b0;
      #1;
      check("zr_count",    DATA_W'(count),    '0);
      check("zr_rb_write", DATA_W'(rb_write), '0);
      check("zr_byp_hit1_after", DATA_W'(byp_hit1), '0);

      // Streaming push+drain across several pointer wraps
      drain_en = 1'b1; ex_valid = 1'b1;
      for (int k = 0; k < 3 * DEPTH; k++) begin
         ex_addr = ADDR_W'(k + 1);
         ex_data = DATA_W'(64'h1000 + k);
         #1;
         check("stream_ex_ready", DATA_W'(ex_ready), DATA_W'(1));
         expect_write(ex_addr, ex_data);
         step();
         check("stream_count", DATA_W'(count), DATA_W'(1));
      end
      ex_valid = 1'b0;
      wait_empty(10);

      // Reset mid-run with three pending entries
      drain_en = 1'b0; ex_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ex_addr = ADDR_W'(20 + k);
         ex_data = DATA_W'(64'h500 + k);
         step();
      end
      ex_valid = 1'b0;
      #1;
      check("pre_reset_count", DATA_W'(count), DATA_W'(3));
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_count",    DATA_W'(count),    '0);
      check("midrst_empty",    DATA_W'(empty),    DATA_W'(1));
      check("midrst_rb_write", DATA_W'(rb_write), '0);
      step();
      step();
      reset_n = 1'b1;
      drain_en = 1'b1;
      repeat (6) step();
      check("postrst_empty", DATA_W'(empty), DATA_W'(1));

      check("scoreboard_leftover", DATA_W'(exp_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
